pe_demux_router: RTL and testbench

PE_DEMUX_ROUTER -- requirements
Module: pe_demux_router

---
 rtl/pe_demux_router.sv | 97 +++++++++
 tb/tb_pe_demux_router.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_demux_router.sv
// One-to-NCH demultiplexing router with one-entry output register per channel,
// broadcast support, and saturating drop counter for out-of-range selects.
module pe_demux_router #(
    parameter int DWIDTH = 8,
    parameter int NCH    = 4,
    parameter int SELW   = 2,
    parameter int CNTW   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DWIDTH-1:0] out_data,
    output logic                  drop_pulse,
    output logic [CNTW-1:0]       drop_cnt
);

    typedef enum logic {EMPTY, FULL} chan_t;

    chan_t             st     [NCH];
    chan_t             st_nxt [NCH];
    logic [DWIDTH-1:0] dreg   [NCH];

    logic [NCH-1:0] full;
    logic [NCH-1:0] free;
    logic [NCH-1:0] load;
    logic           sel_ok;
    logic           sel_free;
    logic           accept;
    logic           drop;

    always_comb begin
        full     = '0;
        free     = '0;
        load     = '0;
        sel_ok   = 1'b0;
        sel_free = 1'b0;
        out_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            full[k] = (st[k] == FULL);
            free[k] = ~full[k] | out_ready[k];
            if (in_sel == SELW'(k)) begin
                sel_ok   = 1'b1;
                sel_free = free[k];
            end
        end

        // Out-of-range unicast is always accepted so it can be counted as a drop.
        if (in_bcast)
            in_ready = &free;
        else if (sel_ok)
            in_ready = sel_free;
        else
            in_ready = 1'b1;

        accept = in_valid & in_ready;
        drop   = accept & ~in_bcast & ~sel_ok;

        for (int unsigned k = 0; k < NCH; k++) begin
            load[k]   = accept & (in_bcast | (in_sel == SELW'(k)));
            st_nxt[k] = st[k];
            if (load[k])
                st_nxt[k] = FULL;
            else if (full[k] && out_ready[k])
                st_nxt[k] = EMPTY;
            // Empty channels present zeros so no stale payload is visible.
            out_data[k*DWIDTH +: DWIDTH] = full[k] ? dreg[k] : '0;
        end
        out_valid = full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                st[k]   <= EMPTY;
                dreg[k] <= '0;
            end
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                st[k] <= st_nxt[k];
                if (load[k])
                    dreg[k] <= in_data;
            end
            drop_pulse <= drop;
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_pe_demux_router.sv
// Bench for pe_demux_router: directed table on a 4-channel instance, reset and
// drop sequences, and randomized queue-model scoreboard on a 3-channel instance.
module tb_pe_demux_router;

    logic clk;
    logic rst_n;

    // 4-channel instance
    logic        in_valid, in_ready, in_bcast;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready;
    logic [31:0] out_data;
    logic        drop_pulse;
    logic [7:0]  drop_cnt;

    // 3-channel instance
    logic        d3_valid, d3_ready, d3_bcast;
    logic [7:0]  d3_data;
    logic [1:0]  d3_sel;
    logic [2:0]  d3_ovalid, d3_oready;
    logic [23:0] d3_odata;
    logic        d3_drop;
    logic [7:0]  d3_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pe_demux_router #(.DWIDTH(8), .NCH(4), .SELW(2), .CNTW(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    pe_demux_router #(.DWIDTH(8), .NCH(3), .SELW(2), .CNTW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d3_valid), .in_ready(d3_ready), .in_data(d3_data),
        .in_sel(d3_sel), .in_bcast(d3_bcast),
        .out_valid(d3_ovalid), .out_ready(d3_oready), .out_data(d3_odata),
        .drop_pulse(d3_drop), .drop_cnt(d3_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        b;
        logic [3:0]  ord;
        logic [7:0]  d;
        logic        e_ready;
        logic [3:0]  e_ovalid;
        logic [31:0] e_odata;
    } vec_t;

    vec_t tbl [10];

    // Queue model for the 3-channel instance
    logic [7:0] q [3][$];
    int         m_drops;
    logic       m_pulse;

    initial begin
        logic exp_rdy;
        logic acc;
        logic [7:0] exp_byte;
        int lim;
        logic ovalid_seen;

        tbl[0] = '{1'b1, 2'd2, 1'b0, 4'b1111, 8'hA5, 1'b1, 4'b0100, 32'h00A50000};
        tbl[1] = '{1'b1, 2'd1, 1'b0, 4'b1111, 8'h11, 1'b1, 4'b0010, 32'h00001100};
        tbl[2] = '{1'b1, 2'd1, 1'b0, 4'b1101, 8'h22, 1'b0, 4'b0010, 32'h00001100};
        tbl[3] = '{1'b1, 2'd1, 1'b0, 4'b1111, 8'h22, 1'b1, 4'b0010, 32'h00002200};
        tbl[4] = '{1'b0, 2'd3, 1'b0, 4'b0000, 8'hEE, 1'b1, 4'b0010, 32'h00002200};
        tbl[5] = '{1'b1, 2'd0, 1'b1, 4'b0000, 8'h3C, 1'b0, 4'b0010, 32'h00002200};
        tbl[6] = '{1'b1, 2'd0, 1'b1, 4'b1111, 8'h3C, 1'b1, 4'b1111, 32'h3C3C3C3C};
        tbl[7] = '{1'b1, 2'd3, 1'b1, 4'b0111, 8'h55, 1'b0, 4'b1000, 32'h3C000000};
        tbl[8] = '{1'b1, 2'd0, 1'b0, 4'b0111, 8'h66, 1'b1, 4'b1001, 32'h3C000066};
        tbl[9] = '{1'b0, 2'd0, 1'b0, 4'b1111, 8'h00, 1'b1, 4'b0000, 32'h00000000};

        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '0;
        d3_valid = 1'b0; d3_sel = '0; d3_bcast = 1'b0; d3_data = '0; d3_oready = '0;
        #3;
        chk("reset_ovalid", 64'(out_valid), 64'd0);
        chk("reset_odata", 64'(out_data), 64'd0);
        chk("reset_drop_pulse", 64'(drop_pulse), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        #9 rst_n = 1'b1;
        step();

        // Directed table on the 4-channel instance
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].v; in_sel = tbl[i].sel; in_bcast = tbl[i].b;
            out_ready = tbl[i].ord; in_data = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ready));
            step();
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ovalid));
            chk($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_odata));
        end

        // Async reset with channels 1 and 3 held
        in_valid = 1'b1; in_bcast = 1'b0; out_ready = 4'b0000;
        in_sel = 2'd1; in_data = 8'h11; step();
        in_sel = 2'd3; in_data = 8'h33; step();
        in_valid = 1'b0;
        chk("pre_rst_ovalid", 64'(out_valid), 64'b1010);
        chk("pre_rst_odata", 64'(out_data), 64'h33001100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ovalid", 64'(out_valid), 64'd0);
        chk("async_rst_odata", 64'(out_data), 64'd0);
        in_sel = 2'd1; #1;
        chk("rst_ready_unicast", 64'(in_ready), 64'd1);
        in_bcast = 1'b1; #1;
        chk("rst_ready_bcast", 64'(in_ready), 64'd1);
        in_bcast = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
        step();
        chk("rst_no_capture", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        in_sel = 2'd3; in_data = 8'h99; #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; out_ready = 4'b1111;
        chk("post_rst_ovalid", 64'(out_valid), 64'b1000);
        chk("post_rst_odata", 64'(out_data), 64'h99000000);
        step();
        chk("post_rst_drain", 64'(out_valid), 64'd0);

        // 300 out-of-range beats on the 3-channel instance
        d3_valid = 1'b1; d3_sel = 2'd3; d3_bcast = 1'b0; d3_oready = 3'b000; d3_data = 8'h5A;
        ovalid_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            chk("drop_in_ready", 64'(d3_ready), 64'd1);
            step();
            lim = (i + 1 > 255) ? 255 : i + 1;
            chk("drop_pulse", 64'(d3_drop), 64'd1);
            chk("drop_cnt_sat", 64'(d3_cnt), 64'(lim));
            if (d3_ovalid != 3'b000) ovalid_seen = 1'b1;
        end
        d3_valid = 1'b0;
        step();
        chk("drop_pulse_clear", 64'(d3_drop), 64'd0);
        chk("drop_cnt_final", 64'(d3_cnt), 64'd255);
        chk("drop_no_ovalid", 64'(ovalid_seen), 64'd0);

        // Random stress against queue model
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        m_drops = 0;
        m_pulse = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            d3_valid  = ($urandom_range(0, 9) < 7);
            d3_sel    = 2'($urandom_range(0, 3));
            d3_bcast  = ($urandom_range(0, 7) == 0);
            d3_oready = 3'($urandom);
            d3_data   = 8'($urandom);
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_byte = (q[k].size() != 0) ? q[k][0] : 8'h00;
                chk($sformatf("rnd_ovalid%0d", k), 64'(d3_ovalid[k]), 64'(q[k].size() != 0));
                chk($sformatf("rnd_odata%0d", k), 64'(d3_odata[k*8 +: 8]), 64'(exp_byte));
            end
            chk("rnd_drop_pulse", 64'(d3_drop), 64'(m_pulse));
            chk("rnd_drop_cnt", 64'(d3_cnt), 64'((m_drops > 255) ? 255 : m_drops));

            if (d3_bcast) begin
                exp_rdy = 1'b1;
                for (int k = 0; k < 3; k++)
                    if (q[k].size() != 0 && !d3_oready[k]) exp_rdy = 1'b0;
            end else if (d3_sel >= 2'd3) begin
                exp_rdy = 1'b1;
            end else begin
                exp_rdy = (q[d3_sel].size() == 0) || d3_oready[d3_sel];
            end
            chk("rnd_in_ready", 64'(d3_ready), 64'(exp_rdy));

            acc = d3_valid && exp_rdy;
            for (int k = 0; k < 3; k++)
                if (q[k].size() != 0 && d3_oready[k]) void'(q[k].pop_front());
            m_pulse = 1'b0;
            if (acc) begin
                if (d3_bcast) begin
                    for (int k = 0; k < 3; k++) q[k].push_back(d3_data);
                end else if (d3_sel >= 2'd3) begin
                    m_pulse = 1'b1;
                    m_drops++;
                end else begin
                    q[d3_sel].push_back(d3_data);
                end
            end
            step();
        end
        d3_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
